// File: rtl/serial_accum_ctrl.sv
// serial_accum_ctrl: bit-serial accumulator controller that time-shares one
// external combinational 1-bit full-adder cell. Each accepted operand is added
// LSB-first into the accumulator over WIDTH cycles.
//
// Build option: define SERIAL_ACCUM_SAT_EN to saturate acc to all ones when an
// add carries out of the top bit; otherwise acc wraps modulo 2^WIDTH.
//
// Handshake: start is a level request sampled only in IDLE (ignored while busy
// or in DONE, never queued); busy is high for exactly the WIDTH shift cycles;
// done is a one-cycle pulse in the cycle after the commit edge, when acc/ovf
// already hold the new result. clr aborts from any state with no done pulse.
module serial_accum_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  // Accumulator shift register after this cycle's sum bit enters at the top.
  logic [WIDTH-1:0]   sum_word;
  logic               last_bit;

  assign sum_word = {fa_sum, sh_a_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Cell operands come straight from registers and are forced low off-SHIFT.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == SHIFT) begin
      fa_a   = sh_a_q[0];
      fa_b   = sh_b_q[0];
      fa_cin = c_q;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    acc  = acc_q;
    ovf  = ovf_q;
  end

  // Next-state and datapath update; clr overrides everything but rst.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      sh_a_d  = '0;
      sh_b_d  = '0;
      c_d     = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_a_d  = acc_q;
            sh_b_d  = din;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sh_a_d = sum_word;
          sh_b_d = sh_b_q >> 1;
          c_d    = fa_cout;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_bit) begin
`ifdef SERIAL_ACCUM_SAT_EN
            acc_d = fa_cout ? {WIDTH{1'b1}} : sum_word;
`else
            acc_d = sum_word;
`endif
            ovf_d   = fa_cout;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
